// File: rtl/lbm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lbm_pkg
// Purpose  : Shared defaults, D2Q9 direction indices and FSM encoding for
//            the lattice-Boltzmann distribution bank.
// Revision : 1.0 - initial release
// ============================================================================
package lbm_pkg;

    localparam int c_lbm_nch   = 9;
    localparam int c_lbm_dw    = 16;
    localparam int c_lbm_depth = 2500;
    localparam int c_lbm_aw    = 12;
    localparam int c_lbm_cw    = 4;

    // D2Q9 direction indices: rest, then N and clockwise round the compass
    typedef enum logic [3:0] {
        c_c0  = 4'd0,
        c_cn  = 4'd1,
        c_cne = 4'd2,
        c_ce  = 4'd3,
        c_cse = 4'd4,
        c_cs  = 4'd5,
        c_csw = 4'd6,
        c_cw  = 4'd7,
        c_cnw = 4'd8
    } lbm_dir_e;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_init = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/lbm_dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : lbm_dp_ram
// Purpose  : Single-clock DEPTH x DW RAM, one write port and one registered
//            read port (read-before-write on a same-address collision).
// Revision : 1.0 - initial release
// ============================================================================
module lbm_dp_ram
    import lbm_pkg::*;
#(
    parameter int DW    = c_lbm_dw,
    parameter int DEPTH = c_lbm_depth,
    parameter int AW    = c_lbm_aw
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/lbm_dist_bank.sv
`default_nettype none
// ============================================================================
// Module   : lbm_dist_bank
// Purpose  : NCH-channel ping-pong distribution storage with init fill,
//            bank swap and solver-priority host readback.
//            Optional macro LBM_BANK_STEP_CNT_EN enables the swap counter.
// Revision : 1.0 - initial release
// ============================================================================
module lbm_dist_bank
    import lbm_pkg::*;
#(
    parameter int NCH   = c_lbm_nch,
    parameter int DW    = c_lbm_dw,
    parameter int DEPTH = c_lbm_depth,
    parameter int AW    = c_lbm_aw,
    parameter int CW    = c_lbm_cw
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic [NCH*DW-1:0] init_vals,
    output logic              init_done,
    output logic              busy,
    input  logic              rd_en,
    input  logic [NCH*AW-1:0] rd_addr,
    output logic [NCH*DW-1:0] rd_data,
    output logic              rd_valid,
    input  logic [NCH-1:0]    wr_en,
    input  logic [NCH*AW-1:0] wr_addr,
    input  logic [NCH*DW-1:0] wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              cur_sel,
    input  logic              host_req,
    input  logic [CW-1:0]     host_ch,
    input  logic [AW-1:0]     host_addr,
    output logic              host_ack,
    output logic              host_valid,
    output logic [DW-1:0]     host_data,
    output logic [31:0]       step_count
);

    localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);
    localparam logic [CW:0]   c_nch   = (CW+1)'(NCH);

    logic [1:0]     r_state;
    logic [AW-1:0]  r_cnt;
    logic           r_cur_sel;
    logic           r_init_done;
    logic           r_swap_ack;
    logic           r_rd_valid;
    logic           r_rd_bank;
    logic [NCH-1:0] r_rd_oor;
    logic           r_host_valid;
    logic           r_host_bank;
    logic           r_host_oor;
    logic [CW-1:0]  r_host_ch;

    logic           w_run;
    logic           w_init;
    logic           w_init_last;
    logic           w_rd_fire;
    logic           w_host_grant;
    logic           w_swap;
    logic           w_re;
    logic [1:0]     w_we    [NCH];
    logic [AW-1:0]  w_waddr [NCH];
    logic [AW-1:0]  w_raddr [NCH];
    logic [DW-1:0]  w_wdata [NCH];
    logic [DW-1:0]  w_q     [2][NCH];

    assign w_run        = (r_state == c_st_run);
    assign w_init       = (r_state == c_st_init);
    assign w_init_last  = w_init && (r_cnt == c_last);
    assign w_rd_fire    = w_run && rd_en;
    assign w_host_grant = w_run && host_req && !rd_en;
    assign w_swap       = w_run && swap_req && !init_start;
    assign w_re         = w_rd_fire || w_host_grant;

    // Bit b of w_we[k] enables bank b of channel k; solver writes hit !cur_sel
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_raddr[k] = rd_en ? rd_addr[k*AW +: AW] : host_addr;
            w_we[k]    = 2'b00;
            if (w_init) begin
                w_we[k]    = 2'b11;
                w_waddr[k] = r_cnt;
                w_wdata[k] = init_vals[k*DW +: DW];
            end else begin
                w_waddr[k] = wr_addr[k*AW +: AW];
                w_wdata[k] = wr_data[k*DW +: DW];
                if (w_run && wr_en[k] && ({1'b0, wr_addr[k*AW +: AW]} < c_depth)) begin
                    w_we[k] = r_cur_sel ? 2'b01 : 2'b10;
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        for (genvar b = 0; b < 2; b++) begin : g_bank
            logic [DW-1:0] w_rdata;
            lbm_dp_ram #(
                .DW    (DW),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_ram (
                .clk     (clk),
                .i_we    (w_we[k][b]),
                .i_waddr (w_waddr[k]),
                .i_wdata (w_wdata[k]),
                .i_re    (w_re),
                .i_raddr (w_raddr[k]),
                .o_rdata (w_rdata)
            );
            assign w_q[b][k] = w_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_cur_sel    <= 1'b0;
            r_init_done  <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_rd_oor     <= '0;
            r_host_valid <= 1'b0;
            r_host_bank  <= 1'b0;
            r_host_oor   <= 1'b0;
            r_host_ch    <= '0;
        end else begin
            r_init_done  <= 1'b0;
            r_swap_ack   <= w_swap;
            r_rd_valid   <= w_rd_fire;
            r_rd_bank    <= r_cur_sel;
            r_host_valid <= w_host_grant;
            r_host_bank  <= r_cur_sel;
            r_host_ch    <= host_ch;
            r_host_oor   <= ({1'b0, host_addr} >= c_depth) || ({1'b0, host_ch} >= c_nch);
            for (int k = 0; k < NCH; k++) begin
                r_rd_oor[k] <= ({1'b0, rd_addr[k*AW +: AW]} >= c_depth);
            end
            case (r_state)
                c_st_idle: begin
                    if (init_start) begin
                        r_state <= c_st_init;
                        r_cnt   <= '0;
                    end
                end
                c_st_init: begin
                    if (w_init_last) begin
                        r_state     <= c_st_run;
                        r_cur_sel   <= 1'b0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                c_st_run: begin
                    if (init_start) begin
                        r_state <= c_st_init;
                        r_cnt   <= '0;
                    end else if (swap_req) begin
                        r_cur_sel <= !r_cur_sel;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // RAM read registers are unreset; gate them so idle and out-of-range reads give 0
    always_comb begin
        rd_data   = '0;
        host_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_rd_valid && !r_rd_oor[k]) begin
                rd_data[k*DW +: DW] = w_q[r_rd_bank][k];
            end
            if (r_host_valid && !r_host_oor && (r_host_ch == CW'(k))) begin
                host_data = w_q[r_host_bank][k];
            end
        end
    end

`ifdef LBM_BANK_STEP_CNT_EN
    logic [31:0] r_step_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_count <= 32'd0;
        end else if (w_init_last) begin
            r_step_count <= 32'd0;
        end else if (w_swap) begin
            r_step_count <= r_step_count + 32'd1;
        end
    end

    assign step_count = r_step_count;
`else
    assign step_count = 32'd0;
`endif

    assign init_done  = r_init_done;
    assign busy       = w_init;
    assign rd_valid   = r_rd_valid;
    assign swap_ack   = r_swap_ack;
    assign cur_sel    = r_cur_sel;
    assign host_ack   = w_host_grant;
    assign host_valid = r_host_valid;

endmodule
`default_nettype wire

// File: tb/tb_lbm_dist_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbm_dist_bank
// Purpose  : Self-checking bench for lbm_dist_bank: array-based bank model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbm_dist_bank;

    localparam int NCH   = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 2500;
    localparam int AW    = 12;
    localparam int CW    = 4;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              init_start = 1'b0;
    logic [NCH*DW-1:0] init_vals  = '0;
    logic              init_done;
    logic              busy;
    logic              rd_en      = 1'b0;
    logic [NCH*AW-1:0] rd_addr    = '0;
    logic [NCH*DW-1:0] rd_data;
    logic              rd_valid;
    logic [NCH-1:0]    wr_en      = '0;
    logic [NCH*AW-1:0] wr_addr    = '0;
    logic [NCH*DW-1:0] wr_data    = '0;
    logic              swap_req   = 1'b0;
    logic              swap_ack;
    logic              cur_sel;
    logic              host_req   = 1'b0;
    logic [CW-1:0]     host_ch    = '0;
    logic [AW-1:0]     host_addr  = '0;
    logic              host_ack;
    logic              host_valid;
    logic [DW-1:0]     host_data;
    logic [31:0]       step_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    lbm_dist_bank #(
        .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_vals  (init_vals),
        .init_done  (init_done),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .cur_sel    (cur_sel),
        .host_req   (host_req),
        .host_ch    (host_ch),
        .host_addr  (host_addr),
        .host_ack   (host_ack),
        .host_valid (host_valid),
        .host_data  (host_data),
        .step_count (step_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: mode 0 idle, 1 filling, 2 running
    logic [DW-1:0] m_mem [2][NCH][DEPTH];
    int            m_mode;
    int            m_cnt;
    int            m_cur;
    logic [31:0]   m_step;
    logic          e_rd_valid, e_host_valid, e_init_done, e_swap_ack;
    logic [DW-1:0] e_rd_data [NCH];
    logic [DW-1:0] e_host_data;

    task automatic model_step();
        int a;
        int c;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_cur = 0; m_step = 0;
            e_rd_valid = 0; e_host_valid = 0; e_init_done = 0; e_swap_ack = 0;
            e_host_data = 0;
            for (int k = 0; k < NCH; k++) e_rd_data[k] = 0;
            return;
        end
        e_rd_valid = 0; e_host_valid = 0; e_init_done = 0; e_swap_ack = 0;
        if (m_mode == 0) begin
            if (init_start) begin m_mode = 1; m_cnt = 0; end
        end else if (m_mode == 1) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                for (int b = 0; b < 2; b++)
                    for (int k = 0; k < NCH; k++)
                        for (int i = 0; i < DEPTH; i++)
                            m_mem[b][k][i] = init_vals[k*DW +: DW];
                m_mode = 2; m_cur = 0; m_step = 0; e_init_done = 1;
            end
        end else begin
            if (rd_en) begin
                e_rd_valid = 1;
                for (int k = 0; k < NCH; k++) begin
                    a = int'(rd_addr[k*AW +: AW]);
                    e_rd_data[k] = (a < DEPTH) ? m_mem[m_cur][k][a] : '0;
                end
            end else if (host_req) begin
                e_host_valid = 1;
                c = int'(host_ch);
                a = int'(host_addr);
                e_host_data = (c < NCH && a < DEPTH) ? m_mem[m_cur][c][a] : '0;
            end
            for (int k = 0; k < NCH; k++) begin
                a = int'(wr_addr[k*AW +: AW]);
                if (wr_en[k] && a < DEPTH) m_mem[1 - m_cur][k][a] = wr_data[k*DW +: DW];
            end
            if (init_start) begin
                m_mode = 1; m_cnt = 0;
            end else if (swap_req) begin
                m_cur = 1 - m_cur; m_step = m_step + 1; e_swap_ack = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // ---------------- every-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("busy", busy, m_mode == 1);
                chk("cur_sel", cur_sel, m_cur[0]);
                chk("init_done", init_done, e_init_done);
                chk("swap_ack", swap_ack, e_swap_ack);
                chk("rd_valid", rd_valid, e_rd_valid);
                if (e_rd_valid)
                    for (int k = 0; k < NCH; k++) chk("rd_data", rd_data[k*DW +: DW], e_rd_data[k]);
                chk("host_ack", host_ack, (m_mode == 2) && host_req && !rd_en);
                chk("host_valid", host_valid, e_host_valid);
                if (e_host_valid) chk("host_data", host_data, e_host_data);
`ifdef LBM_BANK_STEP_CNT_EN
                chk("step_count", step_count, m_step);
`else
                chk("step_count", step_count, 32'd0);
`endif
            end
        end
    end

    // ---------------- directed stimulus helpers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [NCH*DW-1:0] vals);
        int n = 0;
        init_vals  = vals;
        init_start = 1'b1;
        cyc();
        init_start = 1'b0;
        while (busy && n < 3000) begin
            n++;
            cyc();
        end
        chk("init_busy_cycles", n, 2500);
        chk("init_done_pulse", init_done, 1'b1);
        chk("cur_sel_after_init", cur_sel, 1'b0);
    endtask

    task automatic rd_all(input int a, input logic [DW-1:0] exp, input string nm);
        for (int k = 0; k < NCH; k++) rd_addr[k*AW +: AW] = AW'(a);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk({nm, "_valid"}, rd_valid, 1'b1);
        for (int k = 0; k < NCH; k++) chk(nm, rd_data[k*DW +: DW], exp);
    endtask

    task automatic rd_one(input int ch, input int a, input logic [DW-1:0] exp, input string nm);
        rd_addr[ch*AW +: AW] = AW'(a);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk(nm, rd_data[ch*DW +: DW], exp);
    endtask

    task automatic wr_one(input int ch, input int a, input logic [DW-1:0] d);
        wr_en[ch]            = 1'b1;
        wr_addr[ch*AW +: AW] = AW'(a);
        wr_data[ch*DW +: DW] = d;
        cyc();
        wr_en = '0;
    endtask

    task automatic swap_pulse();
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        chk("swap_ack_pulse", swap_ack, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*DW-1:0] vals;

        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_host_data", host_data, 16'h0);
        chk("rst_cur_sel", cur_sel, 1'b0);
        chk("rst_step_count", step_count, 32'd0);
        chk_on = 1'b1;
        rst    = 1'b0;
        cyc();

        // init fill, both banks checked at both ends of the address range
        do_init({NCH{16'h0100}});
        rd_all(0, 16'h0100, "fill_b0_a0");
        rd_all(2499, 16'h0100, "fill_b0_a2499");
        swap_pulse();
        rd_all(0, 16'h0100, "fill_b1_a0");
        rd_all(2499, 16'h0100, "fill_b1_a2499");
        swap_pulse();

        // ping-pong
        wr_one(3, 10, 16'h1234);
        rd_one(3, 10, 16'h0100, "pp_before_swap");
        swap_pulse();
        chk("pp_cur_sel", cur_sel, 1'b1);
        rd_one(3, 10, 16'h1234, "pp_after_swap");

        // read, write and swap in one cycle
        rd_addr[3*AW +: AW] = AW'(10);
        rd_en    = 1'b1;
        swap_req = 1'b1;
        wr_en[3] = 1'b1;
        wr_addr[3*AW +: AW] = AW'(20);
        wr_data[3*DW +: DW] = 16'h5555;
        cyc();
        rd_en = 1'b0; swap_req = 1'b0; wr_en = '0;
        chk("swapcyc_old_bank", rd_data[3*DW +: DW], 16'h1234);
        chk("swapcyc_ack", swap_ack, 1'b1);
        chk("swapcyc_cur_sel", cur_sel, 1'b0);
        rd_one(3, 20, 16'h5555, "swapcyc_write_new_cur");

        // host arbitration against a busy solver
        wr_one(5, 7, 16'h0BEE);
        swap_pulse();
        host_req = 1'b1; host_ch = 4'd5; host_addr = 12'd7;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("host_blocked", host_ack, 1'b0);
            cyc();
        end
        rd_en = 1'b0;
        #1;
        chk("host_ack_grant", host_ack, 1'b1);
        cyc();
        host_req = 1'b0;
        chk("host_valid_after_ack", host_valid, 1'b1);
        chk("host_data_value", host_data, 16'h0BEE);

        // boundaries
        rd_all(2500, 16'h0000, "rd_oor_2500");
        wr_one(0, 4095, 16'hDEAD);
        rd_one(0, 4095, 16'h0000, "rd_oor_4095");
        host_req = 1'b1; host_ch = 4'd9; host_addr = 12'd0;
        cyc();
        host_req = 1'b0;
        chk("host_ch9_valid", host_valid, 1'b1);
        chk("host_ch9_data", host_data, 16'h0000);

        // init beats swap, then reset during the fill
        chk("pre_init_cur_sel", cur_sel, 1'b1);
        init_start = 1'b1; swap_req = 1'b1;
        cyc();
        init_start = 1'b0; swap_req = 1'b0;
        chk("init_swap_no_ack", swap_ack, 1'b0);
        chk("init_swap_busy", busy, 1'b1);
        chk("init_swap_cur_sel", cur_sel, 1'b1);
        repeat (999) cyc();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cur_sel", cur_sel, 1'b0);
        chk("midrst_init_done", init_done, 1'b0);
        chk("midrst_rd_valid", rd_valid, 1'b0);
        chk("midrst_swap_ack", swap_ack, 1'b0);
        chk("midrst_host_valid", host_valid, 1'b0);
        chk("midrst_step_count", step_count, 32'd0);
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        chk("idle_after_rst", busy, 1'b0);

        // distinct per-channel fill, then three swaps
        for (int k = 0; k < NCH; k++) vals[k*DW +: DW] = 16'h0200 + 16'(k);
        do_init(vals);
        for (int k = 0; k < NCH; k++) rd_addr[k*AW +: AW] = AW'(5);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        for (int k = 0; k < NCH; k++) chk("refill_ch", rd_data[k*DW +: DW], 16'h0200 + 16'(k));
        repeat (3) swap_pulse();
`ifdef LBM_BANK_STEP_CNT_EN
        chk("step_count_3", step_count, 32'd3);
`else
        chk("step_count_off", step_count, 32'd0);
`endif
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
